serv_rf_ram_mport_if: RTL and testbench
=======================================

// Module: serv_rf_ram_mport_if
// PURPOSE
//  Bit-serial to SRAM-word adapter for the SERV register file, extended for the FPU.
//  Adds NRD serial read channels (3 for FMA rs3) and two serial write channels.
//  Adds an optional FP register bank stored after the GPRs and CSRs in one single-port-R/single-port-W RAM.
//  Sits between the SERV core/FPU decode and the RF SRAM.
// PARAMETERS
//  width          8       SRAM data width; power of two, ratio=width/W >= NRD+1
//  W              1       serial datapath width (1,2,4)
//  NRD            3       read channels (2 or 3)
//  csr_regs       4       CSR slots placed after the 32 GPRs
//  fp_regs        1       1: 32 FP regs at base FPB=32+csr_regs; 0: no FP bank
//  reset_strategy "MINI"  "MINI" resets control FFs only; "NONE" resets nothing
//  (derived) raw=$clog2(32+csr_regs+32*fp_regs), ratio=width/W, l2r=$clog2(ratio)
//  (derived) CMSB=4-$clog2(W), aw=5+raw-$clog2(width)
// PORTS
//  i_clk     in   1        clock
//  i_rst     in   1        reset: synchronous, active-high
//  i_rreq    in   1        start NRD-channel serial read
//  i_wreq    in   1        start 2-channel serial write
//  o_ready   out  1        rd grant pulse, OR'd combinationally with i_wreq
//  i_rreg    in   NRD*raw  read reg index per channel; ch k at [k*raw+:raw]
//  i_rfp     in   NRD      per-channel FP-bank select
//  o_rdata   out  NRD*W    serial read data; ch k at [k*W+:W]
//  i_wreg0/1 in   raw      write reg index, ch0/ch1
//  i_wfp0/1  in   1        FP-bank select, ch0/ch1
//  i_wen0/1  in   1        write enable per channel; sampled with the first bit
//  i_wdata0/1 in  W        serial write data, LSB first
//  o_waddr   out  aw       RAM write address
//  o_wdata   out  width    RAM write data
//  o_wen     out  1        RAM write strobe
//  o_raddr   out  aw       RAM read address
//  o_ren     out  1        RAM read strobe
//  i_rdata   in   width    RAM read data, 1-cycle latency after o_ren
// BEHAVIOUR
//  Addressing
//   - eff = fp ? FPB+reg[4:0] : reg.
//   - o_*addr = {eff, chunk}, chunk in 0..32/width-1; width==32 -> o_*addr = eff.
//  Read
//   - i_rreq in cycle T: rcnt <= 0. Phase p = rcnt[l2r-1:0]; chunk = rcnt[CMSB:l2r].
//   - At phase k<NRD: o_ren=1 and o_raddr = channel k's chunk address.
//   - Ch k data arrives at phase k+1 and is staged.
//   - At phase NRD all channels load their output shift registers in parallel, then shift W/cycle.
//   - o_ready pulses 1 cycle at T+NRD. Bit 0 of all channels appears at T+NRD+1.
//   - 32/W consecutive output cycles; no gaps between chunks.
//   - o_ren stays 0 outside phases 0..NRD-1 and after the final chunk's issue.
//   - Shifted-out positions fill with 0.
//   - i_rreq while a read is active restarts the read from chunk 0. Inputs are sampled at issue time.
//  Write
//   - Cycle after i_wreq: ch0/ch1 shift in W bits/cycle. i_wen0/1 are latched at that first bit.
//   - Every ratio cycles a chunk completes and both words copy to hold registers (double-buffered).
//   - Write cycle +1: o_wen = wen0_l, ch0 address.
//   - Write cycle +2: o_wen = wen1_l, ch1 address.
//   - Shifting continues meanwhile. The last chunk's ch1 write lands 2 cycles after the last bit.
//   - wen=0 on a channel suppresses only that channel's strobe; the address is don't-care.
//  Concurrency, reset
//   - Read and write run on independent counters; simultaneous i_rreq and i_wreq are legal.
//   - Reset values: o_ready=0 (if i_wreq=0), o_wen=0, o_ren=0; counters idle.
//   - Reset mid-operation aborts with no further strobes from the next cycle; partial writes stay.
//   - o_rdata is 0 after reset in MINI; with "NONE", o_rdata is undefined until the first read.
// STRUCTURE
//  - Package serv_rf_pkg holds FPB, raw/aw/ratio derivation functions and the phase constants.
//  - Sub-module serv_rf_rd_lane (staging + shift register per channel) is instantiated NRD times.
//  - Write side is inline.
// TESTING (width=8, W=1, NRD=3, csr_regs=4, fp_regs=1, behavioural 1-cycle RAM model)
//  1. i_rst 2 cycles with reqs idle -> o_ready=0, o_wen=0, o_ren=0 each cycle.
//  2. RAM x5=0xA5A5A5A5, x6=0x0F0F0F0F, x7=0x80000001; i_rreq at T
//     -> o_raddr {5,0},{6,0},{7,0} at T+1..T+3; o_ready at T+3.
//     -> o_rdata streams all 3 words LSB-first over T+4..T+35.
//  3. i_wreq; wreg0=3 data 0xDEADBEEF, wreg1=9 data 0x12345678, wen both 1
//     -> 8 strobes alternating ch0/ch1; RAM x3/x9 match.
//  4. Read ch2 with i_rfp[2]=1, reg 5 -> o_raddr eff index 41 (FPB=36).
//     Write ch1 i_wfp1=1, reg 31 -> addr eff 67.
//  5. wen0=0, wen1=1 -> only 4 strobes, all ch1; x3 unchanged.
//     Simultaneous i_rreq+i_wreq -> both complete correctly.
//  6. i_rst at T+10 of a read -> o_ren=0 from T+11, no o_ready pulse.
//     Re-run at W=2, width=16 -> same data results.

Source files
------------

// File: rtl/serv_rf_pkg.sv
// Shared constants and derivation helpers for the multi-port SERV/FPU register file adapter.
package serv_rf_pkg;

  localparam int unsigned GprCount = 32;
  localparam int unsigned WordBits = 32;

  // Index of the first FP register in the combined GPR/CSR/FP address space.
  function automatic int unsigned fp_base(input int unsigned csr_regs);
    return GprCount + csr_regs;
  endfunction

  function automatic int unsigned calc_raw(input int unsigned csr_regs,
                                           input int unsigned fp_regs);
    return $clog2(GprCount + csr_regs + GprCount * fp_regs);
  endfunction

  function automatic int unsigned calc_aw(input int unsigned raw, input int unsigned width);
    return 5 + raw - $clog2(width);
  endfunction

  function automatic int unsigned calc_ratio(input int unsigned width, input int unsigned w);
    return width / w;
  endfunction

  // Read phases: channel k issues at phase k, everything loads at phase nrd.
  function automatic int unsigned ready_phase(input int unsigned nrd);
    return nrd - 1;
  endfunction

  function automatic int unsigned load_phase(input int unsigned nrd);
    return nrd;
  endfunction

endpackage

// File: rtl/serv_rf_rd_lane.sv
// One serial read channel: stages a fetched RAM word, then shifts it out W bits per cycle.
module serv_rf_rd_lane #(
  parameter int unsigned width = 8,
  parameter int unsigned W     = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_capture,
  input  logic             i_load,
  input  logic [width-1:0] i_rdata,
  output logic [W-1:0]     o_q
);

  logic [width-1:0] r_stage;
  logic [width-1:0] r_shift;
  logic [width-1:0] w_word;

  // The last channel's word arrives in the load cycle itself, so bypass the stage.
  assign w_word = i_capture ? i_rdata : r_stage;

  always_ff @(posedge i_clk) begin
    if (i_capture) r_stage <= i_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_shift <= '0;
    else if (i_load) r_shift <= w_word >> W;
    else             r_shift <= r_shift >> W;
  end

  assign o_q = i_load ? w_word[W-1:0] : r_shift[W-1:0];

endmodule

// File: rtl/serv_rf_ram_mport_if.sv
// Bit-serial to SRAM-word adapter with NRD read channels, two write channels and an FP bank.
module serv_rf_ram_mport_if
  import serv_rf_pkg::*;
#(
  parameter int unsigned width          = 8,
  parameter int unsigned W              = 1,
  parameter int unsigned NRD            = 3,
  parameter int unsigned csr_regs       = 4,
  parameter int unsigned fp_regs        = 1,
  parameter string       reset_strategy = "MINI",
  localparam int unsigned raw           = calc_raw(csr_regs, fp_regs),
  localparam int unsigned aw            = calc_aw(raw, width)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rreq,
  input  logic               i_wreq,
  output logic               o_ready,
  input  logic [NRD*raw-1:0] i_rreg,
  input  logic [NRD-1:0]     i_rfp,
  output logic [NRD*W-1:0]   o_rdata,
  input  logic [raw-1:0]     i_wreg0,
  input  logic [raw-1:0]     i_wreg1,
  input  logic               i_wfp0,
  input  logic               i_wfp1,
  input  logic               i_wen0,
  input  logic               i_wen1,
  input  logic [W-1:0]       i_wdata0,
  input  logic [W-1:0]       i_wdata1,
  output logic [aw-1:0]      o_waddr,
  output logic [width-1:0]   o_wdata,
  output logic               o_wen,
  output logic [aw-1:0]      o_raddr,
  output logic               o_ren,
  input  logic [width-1:0]   i_rdata
);

  localparam int unsigned ratio = calc_ratio(width, W);
  localparam int unsigned l2r   = $clog2(ratio);
  localparam int unsigned CMSB  = 4 - $clog2(W);
  localparam int unsigned CW    = 5 - $clog2(width);
  localparam int unsigned RCW   = CMSB + 2;
  localparam bit          ResetEn = (reset_strategy != "NONE");
  localparam logic [raw-1:0] FpBase   = raw'(fp_base(csr_regs));
  localparam logic [RCW-1:0] RdLast   = RCW'(WordBits / W + NRD - 1);
  localparam logic [RCW-1:0] RdReady  = RCW'(ready_phase(NRD));
  localparam logic [l2r-1:0] PhLoad   = l2r'(load_phase(NRD));

  logic w_rst;
  assign w_rst = ResetEn && i_rst;

  // ---------------- Read side ----------------
  logic           r_ract;
  logic [RCW-1:0] r_rcnt;
  logic [l2r-1:0] w_rphase;
  logic           w_rvalid;
  logic           w_load;
  logic [raw-1:0] w_reff;
  logic [raw-1:0] w_reff_ch [NRD];

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_ract <= 1'b0;
      r_rcnt <= '0;
    end else if (i_rreq) begin
      r_ract <= 1'b1;
      r_rcnt <= '0;
    end else if (r_ract) begin
      r_rcnt <= r_rcnt + 1'b1;
      if (r_rcnt == RdLast) r_ract <= 1'b0;
    end
  end

  assign w_rphase = r_rcnt[l2r-1:0];
  // The top counter bit marks the tail where only the final chunk is still shifting out.
  assign w_rvalid = r_ract && !r_rcnt[RCW-1];
  assign w_load   = w_rvalid && (w_rphase == PhLoad);
  assign o_ren    = !w_rst && w_rvalid && (w_rphase < l2r'(NRD));
  assign o_ready  = (!w_rst && r_ract && (r_rcnt == RdReady)) || i_wreq;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic w_cap;
    assign w_reff_ch[k] = (fp_regs != 0 && i_rfp[k]) ? FpBase + raw'(i_rreg[k*raw +: 5])
                                                     : i_rreg[k*raw +: raw];
    assign w_cap = w_rvalid && (w_rphase == l2r'(k + 1));

    serv_rf_rd_lane #(
      .width (width),
      .W     (W)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst     (w_rst),
      .i_capture (w_cap),
      .i_load    (w_load),
      .i_rdata   (i_rdata),
      .o_q       (o_rdata[k*W +: W])
    );
  end

  always_comb begin
    w_reff = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_rphase == l2r'(k)) w_reff = w_reff_ch[k];
    end
  end

  // ---------------- Write side ----------------
  logic              r_wact;
  logic [CMSB:0]     r_wcnt;
  logic              r_wen0_l, r_wen1_l;
  logic              r_wpend1, r_wpend2;
  logic [width-1:0]  r_wsh0, r_wsh1;
  logic [width-1:0]  r_whold0, r_whold1;
  logic [aw-1:0]     r_waddr0, r_waddr1;
  logic [aw-1:0]     w_waddr0, w_waddr1;
  logic [raw-1:0]    w_weff0, w_weff1;
  logic              w_wdone;

  assign w_weff0 = (fp_regs != 0 && i_wfp0) ? FpBase + raw'(i_wreg0[4:0]) : i_wreg0;
  assign w_weff1 = (fp_regs != 0 && i_wfp1) ? FpBase + raw'(i_wreg1[4:0]) : i_wreg1;
  assign w_wdone = r_wact && (r_wcnt[l2r-1:0] == '1);

  if (CW > 0) begin : g_chunk
    assign o_raddr  = {w_reff, r_rcnt[CMSB:l2r]};
    assign w_waddr0 = {w_weff0, r_wcnt[CMSB:l2r]};
    assign w_waddr1 = {w_weff1, r_wcnt[CMSB:l2r]};
  end else begin : g_nochunk
    assign o_raddr  = w_reff;
    assign w_waddr0 = w_weff0;
    assign w_waddr1 = w_weff1;
  end

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_wact   <= 1'b0;
      r_wcnt   <= '0;
      r_wpend1 <= 1'b0;
      r_wpend2 <= 1'b0;
      r_wen0_l <= 1'b0;
      r_wen1_l <= 1'b0;
    end else begin
      r_wpend1 <= w_wdone;
      r_wpend2 <= r_wpend1;
      if (r_wact && r_wcnt == '0) begin
        r_wen0_l <= i_wen0;
        r_wen1_l <= i_wen1;
      end
      if (i_wreq) begin
        r_wact <= 1'b1;
        r_wcnt <= '0;
      end else if (r_wact) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == '1) r_wact <= 1'b0;
      end
    end
  end

  // Hold registers let the next chunk shift in while the previous one is written out.
  always_ff @(posedge i_clk) begin
    if (r_wact) begin
      r_wsh0 <= {i_wdata0, r_wsh0[width-1:W]};
      r_wsh1 <= {i_wdata1, r_wsh1[width-1:W]};
    end
    if (w_wdone) begin
      r_whold0 <= {i_wdata0, r_wsh0[width-1:W]};
      r_whold1 <= {i_wdata1, r_wsh1[width-1:W]};
      r_waddr0 <= w_waddr0;
      r_waddr1 <= w_waddr1;
    end
  end

  assign o_wen   = !w_rst && ((r_wpend1 && r_wen0_l) || (r_wpend2 && r_wen1_l));
  assign o_waddr = r_wpend1 ? r_waddr0 : r_waddr1;
  assign o_wdata = r_wpend1 ? r_whold0 : r_whold1;

endmodule

// File: tb/tb_serv_rf_ram_mport_if.sv
// Self-checking bench: table-driven and random reads/writes against a word-level register model.
module tb_serv_rf_ram_mport_if;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SW    = 1;
  localparam int unsigned NRD   = 3;
  localparam int unsigned CSR   = 4;
  localparam int unsigned FPR   = 1;
  localparam int unsigned RAW   = 7;
  localparam int unsigned AW    = 9;
  localparam int          FPB   = 36;
  localparam int          NREG  = 68;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, rreq, wreq, ready;
  logic [NRD*RAW-1:0]   rreg;
  logic [NRD-1:0]       rfp;
  logic [NRD*SW-1:0]    rdata_s;
  logic [RAW-1:0]       wreg0, wreg1;
  logic                 wfp0, wfp1, wen0, wen1;
  logic [SW-1:0]        wdata0, wdata1;
  logic [AW-1:0]        waddr, raddr;
  logic [WIDTH-1:0]     wdata, ram_rdata;
  logic                 wen, ren;

  serv_rf_ram_mport_if #(
    .width          (WIDTH),
    .W              (SW),
    .NRD            (NRD),
    .csr_regs       (CSR),
    .fp_regs        (FPR),
    .reset_strategy ("MINI")
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_rreq   (rreq),
    .i_wreq   (wreq),
    .o_ready  (ready),
    .i_rreg   (rreg),
    .i_rfp    (rfp),
    .o_rdata  (rdata_s),
    .i_wreg0  (wreg0),
    .i_wreg1  (wreg1),
    .i_wfp0   (wfp0),
    .i_wfp1   (wfp1),
    .i_wen0   (wen0),
    .i_wen1   (wen1),
    .i_wdata0 (wdata0),
    .i_wdata1 (wdata1),
    .o_waddr  (waddr),
    .o_wdata  (wdata),
    .o_wen    (wen),
    .o_raddr  (raddr),
    .o_ren    (ren),
    .i_rdata  (ram_rdata)
  );

  // Behavioural 1-cycle RAM and a word-level register model.
  logic [7:0]  mem    [0:511];
  logic [31:0] ref_rf [0:NREG-1];

  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) ram_rdata <= mem[raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int e, input logic [31:0] v);
    ref_rf[e] = v;
    for (int c = 0; c < 4; c++) mem[e*4 + c] <= v[8*c +: 8];
  endtask

  function automatic logic [31:0] ram_word(input int e);
    return {mem[e*4 + 3], mem[e*4 + 2], mem[e*4 + 1], mem[e*4]};
  endfunction

  function automatic int eff_of(input int r, input bit fp);
    return fp ? FPB + (r % 32) : r;
  endfunction

  task automatic run_read(input int r0, input int r1, input int r2, input logic [2:0] fp,
                          input int e0, input int e1, input int e2);
    int          e [3];
    logic [31:0] wd [3];
    int          r;
    logic        exp_ren;
    e[0] = e0; e[1] = e1; e[2] = e2;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) wd[k] = ref_rf[e[k]];
    rreg = {RAW'(r2), RAW'(r1), RAW'(r0)};
    rfp  = fp;
    rreq = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      if (c == 1) rreq = 1'b0;
      @(negedge clk);
      r = c - 1;
      exp_ren = (r < 32) && ((r % 8) < 3);
      check("rd_ren", ren, exp_ren);
      if (exp_ren) check("rd_raddr", raddr, e[r % 8] * 4 + r / 8);
      check("rd_ready", ready, c == 3);
      if (c >= 4 && c <= 35)
        check("rd_data", rdata_s, {wd[2][c-4], wd[1][c-4], wd[0][c-4]});
      else if (c == 36)
        check("rd_tail_zero", rdata_s, 0);
    end
  endtask

  task automatic run_write(input int r0, input logic f0, input logic [31:0] d0, input logic en0,
                           input int r1, input logic f1, input logic [31:0] d1, input logic en1,
                           input int e0, input int e1);
    logic s0, s1;
    int   nstrobe;
    @(posedge clk); #1;
    wreg0 = RAW'(r0); wfp0 = f0; wreg1 = RAW'(r1); wfp1 = f1;
    wen0 = ~en0; wen1 = ~en1;
    wreq = 1'b1;
    @(negedge clk);
    check("wr_ready", ready, 1);
    nstrobe = 0;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c == 1) wreq = 1'b0;
      wen0 = (c == 1) ? en0 : ~en0;
      wen1 = (c == 1) ? en1 : ~en1;
      wdata0 = (c <= 32) ? d0[c-1] : 1'b0;
      wdata1 = (c <= 32) ? d1[c-1] : 1'b0;
      @(negedge clk);
      s0 = en0 && c >= 9  && c <= 33 && ((c - 9) % 8 == 0);
      s1 = en1 && c >= 10 && c <= 34 && ((c - 10) % 8 == 0);
      check("wr_wen", wen, s0 || s1);
      if (s0) begin
        check("wr_addr0", waddr, e0 * 4 + (c - 9) / 8);
        check("wr_data0", wdata, d0[8*((c-9)/8) +: 8]);
      end
      if (s1) begin
        check("wr_addr1", waddr, e1 * 4 + (c - 10) / 8);
        check("wr_data1", wdata, d1[8*((c-10)/8) +: 8]);
      end
      if (wen) nstrobe++;
    end
    check("wr_strobes", nstrobe, 4 * (int'(en0) + int'(en1)));
    if (en0) ref_rf[e0] = d0;
    if (en1) ref_rf[e1] = d1;
    check("wr_ram0", ram_word(e0), ref_rf[e0]);
    check("wr_ram1", ram_word(e1), ref_rf[e1]);
  endtask

  typedef struct {
    int         r0, r1, r2;
    logic [2:0] fp;
    int         e0, e1, e2;
  } rvec_t;

  rvec_t rtab [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   r0, r1, r2;
    logic [2:0] fp;
    logic f0, f1;
    rst = 1'b1; rreq = 1'b0; wreq = 1'b0; rreg = '0; rfp = '0;
    wreg0 = '0; wreg1 = '0; wfp0 = 1'b0; wfp1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < NREG; i++) set_word(i, $urandom());
    set_word(5, 32'hA5A5A5A5);
    set_word(6, 32'h0F0F0F0F);
    set_word(7, 32'h80000001);

    rtab[0] = '{5, 6, 7, 3'b000, 5, 6, 7};
    rtab[1] = '{5, 6, 5, 3'b100, 5, 6, 41};
    rtab[2] = '{33, 0, 31, 3'b111, 37, 36, 67};
    rtab[3] = '{31, 35, 1, 3'b010, 31, 39, 1};
    rtab[4] = '{0, 35, 3, 3'b000, 0, 35, 3};

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_wen", wen, 0);
      check("rst_ren", ren, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_read(rtab[i].r0, rtab[i].r1, rtab[i].r2, rtab[i].fp,
               rtab[i].e0, rtab[i].e1, rtab[i].e2);

    run_write(3, 1'b0, 32'hDEADBEEF, 1'b1, 9, 1'b0, 32'h12345678, 1'b1, 3, 9);
    run_write(2, 1'b0, $urandom(), 1'b1, 31, 1'b1, 32'hCAFEF00D, 1'b1, 2, 67);
    run_write(3, 1'b0, 32'h11111111, 1'b0, 9, 1'b0, 32'h0BADC0DE, 1'b1, 3, 9);
    check("x3_kept", ram_word(3), 32'hDEADBEEF);
    run_read(3, 9, 31, 3'b100, 3, 9, 67);

    fork
      run_read(5, 6, 7, 3'b000, 5, 6, 7);
      run_write(10, 1'b0, $urandom(), 1'b1, 11, 1'b0, $urandom(), 1'b1, 10, 11);
    join
    run_read(10, 11, 7, 3'b000, 10, 11, 7);

    // Reset ten cycles into a read must abort it cleanly.
    @(posedge clk); #1;
    rreg = {RAW'(7), RAW'(6), RAW'(5)}; rfp = '0; rreq = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      rreq = 1'b0;
      rst  = (c == 10);
      @(negedge clk);
      if (c >= 11) begin
        check("abort_ren", ren, 0);
        check("abort_ready", ready, 0);
        check("abort_wen", wen, 0);
        check("abort_rdata", rdata_s, 0);
      end
    end

    for (int i = 0; i < 5; i++) begin
      fp = 3'($urandom());
      r0 = fp[0] ? $urandom_range(0, 31) : $urandom_range(0, 35);
      r1 = fp[1] ? $urandom_range(0, 31) : $urandom_range(0, 35);
      r2 = fp[2] ? $urandom_range(0, 31) : $urandom_range(0, 35);
      run_read(r0, r1, r2, fp, eff_of(r0, fp[0]), eff_of(r1, fp[1]), eff_of(r2, fp[2]));
    end

    for (int i = 0; i < 4; i++) begin
      f0 = 1'($urandom());
      f1 = 1'($urandom());
      r0 = f0 ? $urandom_range(0, 31) : $urandom_range(0, 35);
      r1 = f1 ? $urandom_range(0, 31) : $urandom_range(0, 35);
      run_write(r0, f0, $urandom(), 1'($urandom()), r1, f1, $urandom(), 1'($urandom()),
                eff_of(r0, f0), eff_of(r1, f1));
      run_read(r0, r1, r0, {1'b0, f1, f0}, eff_of(r0, f0), eff_of(r1, f1), r0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
